ioctl_sdram_loader: RTL and testbench
=====================================

// Module: ioctl_sdram_loader
// PURPOSE
//  Sequences ROM download bytes from data_io into the two SDRAM write ports (CPU ROM, GFX).
//  Pairs bytes into 16-bit words, buffers them in a small FIFO and issues one toggle-handshake
//  write at a time per port. Raises rom_loaded and releases the core reset after a complete download.
//  Sits between data_io and sdram in the arcade top level, on the SDRAM clock domain.
// PARAMETERS
//  GFX_BASE    25'h10000  first byte address routed to port2; port2_a = (addr-GFX_BASE)>>1
//  FIFO_DEPTH  4          word FIFO entries (power of two, 2..16)
//  ROM_INDEX   8'h00      ioctl_index value accepted as ROM data; all other indices ignored
// PORTS
//  clk_sys        in   1   SDRAM-domain clock; all logic rising edge
//  res_n          in   1   async active-low reset
//  ioctl_download in   1   download window active
//  ioctl_index    in   8   download target index
//  ioctl_wr       in   1   byte strobe (level, may last >1 cycle; rising edge = one byte)
//  ioctl_addr     in   25  byte address
//  ioctl_dout     in   8   byte data
//  port1_req      out  1   toggle request, CPU ROM port
//  port1_ack      in   1   toggle ack; transfer done when ack==req
//  port1_a        out  23  word address
//  port1_ds       out  2   byte enables {hi,lo}
//  port1_d        out  16  write data
//  port2_req/ack/a/ds/d    same as port1, GFX port
//  port_we        out  1   write enable to both ports (1 while busy)
//  busy           out  1   FIFO non-empty, pair pending or transfer in flight
//  overflow       out  1   sticky: byte lost to full FIFO; cleared by reset/new download
//  rom_loaded     out  1   sticky: a download finished and drained
//  core_reset     out  1   active-high core reset = ~rom_loaded
// BEHAVIOUR
//  Reset: reqs 0, a/ds/d 0, port_we 0, busy 0, overflow 0, rom_loaded 0, core_reset 1, FIFO empty.
//  Byte capture: rising edge of ioctl_wr with download=1 and index==ROM_INDEX.
//   Even addr: hold byte, pend=1. Odd addr with pend and same word: push {odd,even}, ds=2'b11.
//   Odd addr without matching pend: push lone byte, ds=2'b10 (data duplicated on both lanes).
//   New even byte while pend set (address jump): push old pend as ds=2'b01 first, then hold new.
//   Falling edge of ioctl_download with pend: push pending byte, ds=2'b01.
//   Entry = {port_sel, word_addr, ds, data}; port_sel = (addr >= GFX_BASE).
//  FIFO full at push: entry dropped, overflow<=1. Push+pop same cycle allowed.
//  Dispatcher FSM:
//   IDLE  : FIFO non-empty -> drive selected port a/ds/d from head, toggle its req, pop -> WAIT.
//   WAIT  : selected port ack==req -> IDLE (next issue earliest the following cycle).
//   DONE  : entered from IDLE when FIFO empty, no pend, download low after a download; sets
//           rom_loaded=1 for one transition, then -> IDLE.
//  Latency: strobe edge -> req toggle >=2 cycles (push, then issue). One request outstanding total.
//  Other port's a/ds/d/req hold last values; ack of the non-selected port is ignored.
//  Download rising edge: overflow<=0, pend<=0; rom_loaded stays set (re-download keeps core running
//   unless new ROM_INDEX data arrives, which clears rom_loaded until drained).
//  Non-ROM indices (e.g. NVRAM 8'hff): ignored, no effect on rom_loaded.
//  Async reset mid-transfer: all state cleared; outstanding SDRAM write is abandoned.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: extra port checksum out 16, 16-bit wrapping sum of all accepted
//   bytes; cleared at download rising edge and reset; stable once rom_loaded rises.
//  Not defined: port and adder absent; no other behaviour change.
// TESTING
//  Bytes 0x11@0,0x22@1 -> port1 a=0, ds=11, d=0x2211, one req toggle; ack echo -> busy=0.
//  Bytes @0x0FFFF,0x10000,0x10001 -> port1 a=0x7FFF ds=10; port2 a=0 ds=11; order preserved.
//  Hold ack 200 cycles, stream 8 words -> FIFO fills, 5th+ extra byte sets overflow=1, no reqs lost.
//  Odd-length download ending on 0x33@4 -> on download fall, port1 a=2 ds=01 d=0x3333; then rom_loaded=1, core_reset=0.
//  Download with index 8'hff -> no req toggles, rom_loaded unchanged.
//  res_n low during WAIT -> reqs 0, busy 0, core_reset 1 next cycle; with LOADER_CHECKSUM_EN bytes 1..4 -> checksum=0x000A.

Source files
------------

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader
//   Turns the data_io ROM download byte stream into 16-bit SDRAM writes on two
//   toggle-handshake ports (port1 = CPU ROM, port2 = GFX at and above GFX_BASE).
//   Bytes are paired into words, queued in a small FIFO and dispatched one
//   request at a time. rom_loaded / core_reset track completion of a download.
//   Optional feature: define LOADER_CHECKSUM_EN to add the 16-bit byte-sum
//   output "checksum".
module ioctl_sdram_loader #(
    parameter logic [24:0] GFX_BASE   = 25'h10000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  ROM_INDEX  = 8'h00
) (
    input  logic        clk_sys,
    input  logic        res_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        busy,
    output logic        overflow,
    output logic        rom_loaded,
    output logic        core_reset
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // FIFO entry layout: {port_sel, word_addr[22:0], ds[1:0], data[15:0]}
    localparam int ENT_W = 1 + 23 + 2 + 16;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Build a FIFO entry from a byte address; GFX addresses are rebased to port2.
    function automatic logic [ENT_W-1:0] make_entry(input logic [24:0] addr,
                                                    input logic [1:0]  ds,
                                                    input logic [15:0] data);
        logic        sel;
        logic [24:0] off;
        sel = (addr >= GFX_BASE);
        off = sel ? (addr - GFX_BASE) : addr;
        return {sel, 23'(off >> 1), ds, data};
    endfunction

    // ---- stage 0: strobe edge detection and byte pairing ----
    logic              wr_p0;
    logic              dl_p0;
    logic              wr_rise;
    logic              dl_rise;
    logic              dl_fall;
    logic              vld_p0;
    logic              pend;
    logic              pend_live;
    logic [24:0]       pend_addr;
    logic [7:0]        pend_data;
    logic              push_p0;
    logic [ENT_W-1:0]  push_ent;
    logic              hold_new;
    logic              clr_pend;

    assign wr_rise   = ioctl_wr & ~wr_p0;
    assign dl_rise   = ioctl_download & ~dl_p0;
    assign dl_fall   = ~ioctl_download & dl_p0;
    assign vld_p0    = wr_rise & ioctl_download & (ioctl_index == ROM_INDEX);
    // A pending byte from a previous download is discarded when a new one starts.
    assign pend_live = pend & ~dl_rise;

    // Previous-cycle copies of the strobe and download window for edge detection.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            wr_p0 <= 1'b0;
            dl_p0 <= 1'b0;
        end else begin
            wr_p0 <= ioctl_wr;
            dl_p0 <= ioctl_download;
        end
    end

    // Decide what (if anything) to push this cycle and how the pending byte changes.
    always_comb begin
        push_p0  = 1'b0;
        push_ent = '0;
        hold_new = 1'b0;
        clr_pend = 1'b0;
        if (dl_fall && pend) begin
            push_p0  = 1'b1;
            push_ent = make_entry(pend_addr, 2'b01, {pend_data, pend_data});
            clr_pend = 1'b1;
        end else if (vld_p0) begin
            if (!ioctl_addr[0]) begin
                hold_new = 1'b1;
                if (pend_live) begin
                    push_p0  = 1'b1;
                    push_ent = make_entry(pend_addr, 2'b01, {pend_data, pend_data});
                end
            end else if (pend_live && (pend_addr[24:1] == ioctl_addr[24:1])) begin
                push_p0  = 1'b1;
                push_ent = make_entry(ioctl_addr, 2'b11, {ioctl_dout, pend_data});
                clr_pend = 1'b1;
            end else begin
                // Lone odd byte; an unrelated pending even byte stays held until flushed.
                push_p0  = 1'b1;
                push_ent = make_entry(ioctl_addr, 2'b10, {ioctl_dout, ioctl_dout});
            end
        end
    end

    // Pending-even-byte flag.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n)
            pend <= 1'b0;
        else if (hold_new)
            pend <= 1'b1;
        else if (clr_pend || dl_rise)
            pend <= 1'b0;
    end

    // Pending byte payload; only meaningful while pend is set.
    always_ff @(posedge clk_sys) begin
        if (hold_new) begin
            pend_addr <= ioctl_addr;
            pend_data <= ioctl_dout;
        end
    end

    // ---- stage 1: word FIFO ----
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              do_push;
    logic              do_drop;
    logic [ENT_W-1:0]  head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign do_push    = push_p0 & (~fifo_full | pop);
    assign do_drop    = push_p0 & fifo_full & ~pop;
    assign head       = mem[rd_ptr];

    // FIFO storage.
    always_ff @(posedge clk_sys) begin
        if (do_push)
            mem[wr_ptr] <= push_ent;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)
                count <= count + 1'b1;
            else if (!do_push && pop)
                count <= count - 1'b1;
        end
    end

    // ---- stage 2: dispatcher ----
    state_t state;
    state_t state_nxt;
    logic   issue;
    logic   set_loaded;
    logic   port_sel;
    logic   dl_seen;
    logic   sel_ack;
    logic   sel_req;

    assign sel_ack = port_sel ? port2_ack : port1_ack;
    assign sel_req = port_sel ? port2_req : port1_req;

    // Dispatcher state register.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Dispatcher next-state: issue from FIFO head, wait for ack, or signal completion.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        pop        = 1'b0;
        set_loaded = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    issue     = 1'b1;
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end else if (!pend && !ioctl_download && dl_seen) begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                if (sel_ack == sel_req)
                    state_nxt = S_IDLE;
            end
            S_DONE: begin
                set_loaded = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Port outputs: only the selected port is updated; the other holds its last values.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            port_sel  <= 1'b0;
            port1_req <= 1'b0;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
            port2_req <= 1'b0;
            port2_a   <= '0;
            port2_ds  <= '0;
            port2_d   <= '0;
        end else if (issue) begin
            port_sel <= head[ENT_W-1];
            if (head[ENT_W-1]) begin
                port2_a   <= head[40:18];
                port2_ds  <= head[17:16];
                port2_d   <= head[15:0];
                port2_req <= ~port2_req;
            end else begin
                port1_a   <= head[40:18];
                port1_ds  <= head[17:16];
                port1_d   <= head[15:0];
                port1_req <= ~port1_req;
            end
        end
    end

    // Sticky status: overflow, download-seen and rom_loaded.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            overflow   <= 1'b0;
            dl_seen    <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            if (dl_rise)
                overflow <= 1'b0;
            if (do_drop)
                overflow <= 1'b1;
            if (vld_p0)
                dl_seen <= 1'b1;
            else if (set_loaded)
                dl_seen <= 1'b0;
            if (vld_p0)
                rom_loaded <= 1'b0;
            else if (set_loaded)
                rom_loaded <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running 16-bit sum of accepted ROM bytes, restarted with each download.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n)
            checksum <= '0;
        else if (dl_rise && vld_p0)
            checksum <= {8'h00, ioctl_dout};
        else if (dl_rise)
            checksum <= '0;
        else if (vld_p0)
            checksum <= checksum + {8'h00, ioctl_dout};
    end
`endif

    assign busy       = ~fifo_empty | pend | (state == S_WAIT);
    assign port_we    = busy;
    assign core_reset = ~rom_loaded;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Testbench for ioctl_sdram_loader: scoreboard of expected SDRAM write
// transactions compared against requests observed on both ports.
module tb_ioctl_sdram_loader;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        res_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port1_req, port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        port_we, busy, overflow, rom_loaded, core_reset;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int errors = 0;
    int checks = 0;
    logic ack_hold = 1'b0;

    // Transaction = {port, a[22:0], ds[1:0], d[15:0]}
    logic [41:0] exp_q[$];
    logic [41:0] obs_q[$];

    always #5 clk_sys = ~clk_sys;

    ioctl_sdram_loader #(
        .GFX_BASE  (25'h10000),
        .FIFO_DEPTH(DEPTH),
        .ROM_INDEX (8'h00)
    ) dut (
        .clk_sys       (clk_sys),
        .res_n         (res_n),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .port1_req     (port1_req),
        .port1_ack     (port1_ack),
        .port1_a       (port1_a),
        .port1_ds      (port1_ds),
        .port1_d       (port1_d),
        .port2_req     (port2_req),
        .port2_ack     (port2_ack),
        .port2_a       (port2_a),
        .port2_ds      (port2_ds),
        .port2_d       (port2_d),
        .port_we       (port_we),
        .busy          (busy),
        .overflow      (overflow),
        .rom_loaded    (rom_loaded),
        .core_reset    (core_reset)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    // SDRAM stand-in: echo req onto ack one cycle later unless held.
    initial begin
        port1_ack = 1'b0;
        port2_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (!ack_hold) begin
                port1_ack = port1_req;
                port2_ack = port2_req;
            end
        end
    end

    // Observe request toggles and record the transaction carried with each.
    initial begin
        logic last1, last2;
        last1 = 1'b0;
        last2 = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (res_n !== 1'b1) begin
                last1 = port1_req;
                last2 = port2_req;
            end else begin
                if (port1_req !== last1) begin
                    obs_q.push_back({1'b0, port1_a, port1_ds, port1_d});
                    last1 = port1_req;
                end
                if (port2_req !== last2) begin
                    obs_q.push_back({1'b1, port2_a, port2_ds, port2_d});
                    last2 = port2_req;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required earlier end", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input int hold);
        @(posedge clk_sys);
        #1;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        repeat (hold) @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(posedge clk_sys);
        #1;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic end_dl();
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b0;
        @(posedge clk_sys);
    endtask

    // Wait (bounded) until the DUT is idle and every expected transaction was seen.
    task automatic drain(output bit ok);
        int n;
        n = 0;
        while ((busy === 1'b1 || obs_q.size() < exp_q.size()) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        ok = (n < 2000);
    endtask

    // Wait (bounded) for rom_loaded to rise.
    task automatic wait_loaded(output bit ok);
        int n;
        n = 0;
        while (rom_loaded !== 1'b1 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        ok = (n < 100);
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 8'h00;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);
        checks++; if (port1_req !== 1'b0) begin errors++; $display("FAIL reset_req1: got %b want 0", port1_req); end
        checks++; if (port2_req !== 1'b0) begin errors++; $display("FAIL reset_req2: got %b want 0", port2_req); end
        checks++; if ({port1_a, port1_ds, port1_d} !== 41'h0) begin errors++; $display("FAIL reset_port1: got %h want 0", {port1_a, port1_ds, port1_d}); end
        checks++; if (busy !== 1'b0 || port_we !== 1'b0) begin errors++; $display("FAIL reset_busy: got busy=%b we=%b want 0 0", busy, port_we); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("FAIL reset_loaded: got loaded=%b core_reset=%b want 0 1", rom_loaded, core_reset); end
`ifdef LOADER_CHECKSUM_EN
        checks++; if (checksum !== 16'h0) begin errors++; $display("FAIL reset_checksum: got %h want 0000", checksum); end
`endif
        @(posedge clk_sys);
        #1 res_n = 1'b1;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic test_pair();
        bit ok;
        logic [41:0] e, o;
        start_dl(8'h00);
        send_byte(25'h0, 8'h11, 1);
        exp_q.push_back({1'b0, 23'h0, 2'b11, 16'h2211});
        @(posedge clk_sys);
        #1;
        ioctl_addr = 25'h1;
        ioctl_dout = 8'h22;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        checks++; if (port1_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pair_latency1: got req=%b busy=%b want 0 1", port1_req, busy); end
        @(posedge clk_sys);
        @(negedge clk_sys);
        checks++; if (port1_req !== 1'b1) begin errors++; $display("FAIL pair_latency2: got req=%b want 1", port1_req); end
        ioctl_wr = 1'b0;
        end_dl();
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL pair_drain: got busy=%b obs=%0d want idle", busy, obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL pair_xfer: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL pair_xfer: got %h want %h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pair_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        wait_loaded(ok);
        checks++; if (!ok || core_reset !== 1'b0) begin errors++; $display("FAIL pair_loaded: got loaded=%b core_reset=%b want 1 0", rom_loaded, core_reset); end
    endtask

    task automatic test_boundary();
        bit ok;
        logic [41:0] e, o;
        start_dl(8'h00);
        send_byte(25'h0FFFF, 8'hA1, 1);
        exp_q.push_back({1'b0, 23'h7FFF, 2'b10, 16'hA1A1});
        send_byte(25'h10000, 8'hB2, 1);
        send_byte(25'h10001, 8'hC3, 1);
        exp_q.push_back({1'b1, 23'h0, 2'b11, 16'hC3B2});
        @(negedge clk_sys);
        checks++; if (rom_loaded !== 1'b0) begin errors++; $display("FAIL bound_loaded_clr: got %b want 0", rom_loaded); end
        end_dl();
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bound_drain: got busy=%b obs=%0d want idle", busy, obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bound_xfer: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL bound_xfer: got %h want %h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bound_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        checks++; if (port1_a !== 23'h7FFF || port1_ds !== 2'b10) begin errors++; $display("FAIL bound_hold1: got a=%h ds=%b want 7fff 10", port1_a, port1_ds); end
        wait_loaded(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bound_loaded: got %b want 1", rom_loaded); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [41:0] e, o;
        logic [7:0] lo;
        start_dl(8'h00);
        ack_hold = 1'b1;
        for (int w = 0; w < 8; w++) begin
            lo = 8'h40 + 8'(2 * w);
            if (w < 1 + DEPTH)
                exp_q.push_back({1'b0, 23'h100 + 23'(w), 2'b11, {lo + 8'h01, lo}});
            send_byte(25'h200 + 25'(2 * w), lo, 1);
            send_byte(25'h201 + 25'(2 * w), lo + 8'h01, 1);
        end
        repeat (130) @(negedge clk_sys);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL ovf_outstanding: got %0d reqs want 1", obs_q.size()); end
        checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ovf_flag: got ovf=%b busy=%b want 1 1", overflow, busy); end
        ack_hold = 1'b0;
        end_dl();
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: got busy=%b obs=%0d want idle", busy, obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL ovf_xfer: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL ovf_xfer: got %h want %h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        wait_loaded(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_loaded: got %b want 1", rom_loaded); end
    endtask

    task automatic test_odd_tail();
        bit ok;
        logic [41:0] e, o;
        start_dl(8'h00);
        @(negedge clk_sys);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL tail_ovf_clr: got %b want 0", overflow); end
        checks++; if (rom_loaded !== 1'b1) begin errors++; $display("FAIL tail_loaded_keep: got %b want 1", rom_loaded); end
        send_byte(25'h0, 8'h11, 1);
        send_byte(25'h1, 8'h22, 1);
        exp_q.push_back({1'b0, 23'h0, 2'b11, 16'h2211});
        send_byte(25'h2, 8'h44, 3);
        send_byte(25'h3, 8'h55, 1);
        exp_q.push_back({1'b0, 23'h1, 2'b11, 16'h5544});
        send_byte(25'h4, 8'h33, 1);
        repeat (10) @(negedge clk_sys);
        checks++; if (obs_q.size() != 2 || busy !== 1'b1) begin errors++; $display("FAIL tail_pending: got obs=%0d busy=%b want 2 1", obs_q.size(), busy); end
        checks++; if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("FAIL tail_loaded_clr: got loaded=%b core_reset=%b want 0 1", rom_loaded, core_reset); end
        exp_q.push_back({1'b0, 23'h2, 2'b01, 16'h3333});
        end_dl();
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tail_drain: got busy=%b obs=%0d want idle", busy, obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL tail_xfer: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL tail_xfer: got %h want %h", o, e); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL tail_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        wait_loaded(ok);
        checks++; if (!ok || core_reset !== 1'b0) begin errors++; $display("FAIL tail_loaded: got loaded=%b core_reset=%b want 1 0", rom_loaded, core_reset); end
    endtask

    task automatic test_other_index();
        start_dl(8'hFF);
        for (int i = 0; i < 4; i++)
            send_byte(25'(i), 8'hE0 + 8'(i), 1);
        end_dl();
        repeat (20) @(negedge clk_sys);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL nvram_reqs: got %0d reqs want 0", obs_q.size()); obs_q.delete(); end
        checks++; if (rom_loaded !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nvram_state: got loaded=%b busy=%b want 1 0", rom_loaded, busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [41:0] o;
        start_dl(8'h00);
        ack_hold = 1'b1;
        send_byte(25'h0, 8'h01, 1);
        send_byte(25'h1, 8'h02, 1);
        send_byte(25'h2, 8'h03, 1);
        send_byte(25'h3, 8'h04, 1);
        n = 0;
        while (obs_q.size() < 1 && n < 50) begin @(negedge clk_sys); n++; end
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL mid_xfer: got none want %h", {1'b0, 23'h0, 2'b11, 16'h0201}); end
        else begin o = obs_q.pop_front(); if (o !== {1'b0, 23'h0, 2'b11, 16'h0201}) begin errors++; $display("FAIL mid_xfer: got %h want %h", o, {1'b0, 23'h0, 2'b11, 16'h0201}); end end
`ifdef LOADER_CHECKSUM_EN
        checks++; if (checksum !== 16'h000A) begin errors++; $display("FAIL mid_checksum: got %h want 000a", checksum); end
`endif
        @(posedge clk_sys);
        #3 res_n = 1'b0;
        #1;
        checks++; if (port1_req !== 1'b0 || port2_req !== 1'b0) begin errors++; $display("FAIL mid_reqs: got %b %b want 0 0", port1_req, port2_req); end
        checks++; if (busy !== 1'b0 || port_we !== 1'b0) begin errors++; $display("FAIL mid_busy: got busy=%b we=%b want 0 0", busy, port_we); end
        checks++; if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin errors++; $display("FAIL mid_core_reset: got core_reset=%b loaded=%b want 1 0", core_reset, rom_loaded); end
        ioctl_download = 1'b0;
        exp_q.delete();
        obs_q.delete();
        @(posedge clk_sys);
        #1;
        res_n = 1'b1;
        ack_hold = 1'b0;
        repeat (5) @(negedge clk_sys);
        checks++; if (busy !== 1'b0 || obs_q.size() != 0) begin errors++; $display("FAIL mid_after: got busy=%b reqs=%0d want 0 0", busy, obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_boundary();
        test_overflow();
        test_odd_tail();
        test_other_index();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
